// File: rtl/cordic_arbiter.sv
// Two-requester round-robin arbiter that issues jobs to a single CORDIC core.
// Define CORDIC_ARB_TIMEOUT_EN to abort a job after TIMEOUT_CYCLES WAIT cycles.
module cordic_arbiter #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic       clka,
    input  logic       reset,
    input  logic [1:0] req_valid,
    input  logic [1:0] req_mode,
    output logic [1:0] req_ready,
    output logic       core_start,
    output logic       core_mode,
    input  logic       core_done,
    output logic [1:0] rsp_valid,
    input  logic [1:0] rsp_ready,
    output logic       rsp_err,
    output logic       busy
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] RESP  = 2'd3;

    logic [1:0] state;
    logic       rr;
    logic       id;
    logic       mode_q;
    logic       sel;
    logic       accept;
    logic       wait_expired;

    // With both requesters valid the pointer decides; otherwise the lone valid one wins.
    assign sel    = (req_valid == 2'b11) ? rr : req_valid[1];
    assign accept = (state == IDLE) && (|req_valid) && !reset;

    always_comb begin
        req_ready = 2'b00;
        if (accept) begin
            req_ready[sel] = 1'b1;
        end
    end

`ifdef CORDIC_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] wait_cnt;
    logic          err_q;

    assign wait_expired = (wait_cnt == LIMIT) && !core_done;

    // Counter clears while in ISSUE so it starts at zero on the first WAIT cycle.
    always_ff @(posedge clka) begin
        if (reset) begin
            wait_cnt <= '0;
            err_q    <= 1'b0;
        end else if (state == ISSUE) begin
            wait_cnt <= '0;
        end else if (state == WAIT) begin
            if (core_done) begin
                err_q <= 1'b0;
            end else if (wait_cnt == LIMIT) begin
                err_q <= 1'b1;
            end else begin
                wait_cnt <= wait_cnt + 1'b1;
            end
        end
    end

    assign rsp_err = (state == RESP) && err_q;
`else
    logic [31:0] unused_timeout;

    assign unused_timeout = 32'(TIMEOUT_CYCLES);
    assign wait_expired   = 1'b0;
    assign rsp_err        = 1'b0;
`endif

    always_ff @(posedge clka) begin
        if (reset) begin
            state  <= IDLE;
            rr     <= 1'b0;
            id     <= 1'b0;
            mode_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        id     <= sel;
                        mode_q <= req_mode[sel];
                        state  <= ISSUE;
                    end
                end
                ISSUE: state <= WAIT;
                WAIT: begin
                    if (core_done || wait_expired) begin
                        state <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready[id]) begin
                        rr    <= ~id;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign core_start = (state == ISSUE);
    assign core_mode  = (state != IDLE) && mode_q;
    assign busy       = (state != IDLE);
    assign rsp_valid  = (state != RESP) ? 2'b00 : (id ? 2'b10 : 2'b01);

endmodule

// File: tb/tb_cordic_arbiter.sv
// Directed self-checking bench for cordic_arbiter; expected values are hand-computed.
module tb_cordic_arbiter;

    logic       clka = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] req_valid = 2'b00;
    logic [1:0] req_mode = 2'b00;
    logic [1:0] req_ready;
    logic       core_start;
    logic       core_mode;
    logic       core_done = 1'b0;
    logic [1:0] rsp_valid;
    logic [1:0] rsp_ready = 2'b00;
    logic       rsp_err;
    logic       busy;

    int compare_count = 0;
    int mismatch_count = 0;

    cordic_arbiter #(.TIMEOUT_CYCLES(16)) dut (
        .clka(clka),
        .reset(reset),
        .req_valid(req_valid),
        .req_mode(req_mode),
        .req_ready(req_ready),
        .core_start(core_start),
        .core_mode(core_mode),
        .core_done(core_done),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_err(rsp_err),
        .busy(busy)
    );

    always #5 clka = ~clka;

    task automatic step();
        @(posedge clka);
        #1;
    endtask

    task automatic applyStimulus(input logic [1:0] valid, input logic [1:0] mode,
                                 input logic done, input logic [1:0] rready);
        req_valid = valid;
        req_mode  = mode;
        core_done = done;
        rsp_ready = rready;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compare_count++;
        if (observed !== expected) begin
            mismatch_count++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic resetDut();
        reset = 1'b1;
        applyStimulus(2'b00, 2'b00, 1'b0, 2'b00);
        step();
        reset = 1'b0;
        #1;
    endtask

    // One full job under contention; rsp_ready is held high so RESP lasts one cycle.
    task automatic runJob(input string tag, input logic [1:0] exp_sel, input logic exp_mode);
        checkOutput({tag, "_ready"}, 32'(req_ready), 32'(exp_sel));
        step();
        checkOutput({tag, "_start"}, 32'(core_start), 32'd1);
        checkOutput({tag, "_mode"}, 32'(core_mode), 32'(exp_mode));
        step();
        core_done = 1'b1;
        step();
        core_done = 1'b0;
        checkOutput({tag, "_rsp"}, 32'(rsp_valid), 32'(exp_sel));
        step();
        checkOutput({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        // Reset state, with requests already pending to prove req_ready is gated.
        applyStimulus(2'b11, 2'b11, 1'b1, 2'b11);
        step();
        step();
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_start", 32'(core_start), 32'd0);
        checkOutput("rst_mode", 32'(core_mode), 32'd0);
        checkOutput("rst_rsp", 32'(rsp_valid), 32'd0);
        checkOutput("rst_err", 32'(rsp_err), 32'd0);
        checkOutput("rst_ready", 32'(req_ready), 32'd0);
        resetDut();

        // Single vectoring request from requester 0.
        applyStimulus(2'b01, 2'b01, 1'b0, 2'b00);
        checkOutput("single_ready", 32'(req_ready), 32'd1);
        step();
        checkOutput("single_start", 32'(core_start), 32'd1);
        checkOutput("single_mode", 32'(core_mode), 32'd1);
        checkOutput("single_busy", 32'(busy), 32'd1);
        checkOutput("single_noready", 32'(req_ready), 32'd0);
        applyStimulus(2'b00, 2'b00, 1'b0, 2'b00);
        step();
        checkOutput("single_start_once", 32'(core_start), 32'd0);
        step();
        step();
        checkOutput("single_wait_rsp", 32'(rsp_valid), 32'd0);
        core_done = 1'b1;
        step();
        checkOutput("single_rsp", 32'(rsp_valid), 32'd1);
        checkOutput("single_err", 32'(rsp_err), 32'd0);
        checkOutput("single_resp_mode", 32'(core_mode), 32'd1);
        applyStimulus(2'b00, 2'b00, 1'b0, 2'b01);
        step();
        checkOutput("single_done_busy", 32'(busy), 32'd0);
        checkOutput("single_done_rsp", 32'(rsp_valid), 32'd0);
        checkOutput("single_idle_mode", 32'(core_mode), 32'd0);

        // Contention: both held valid, requester 1 is vectoring.
        resetDut();
        applyStimulus(2'b11, 2'b10, 1'b0, 2'b11);
        runJob("cont0", 2'b01, 1'b0);
        runJob("cont1", 2'b10, 1'b1);
        runJob("cont2", 2'b01, 1'b0);

        // Backpressure: rr now points at requester 1; requester 0 arrives while blocked.
        applyStimulus(2'b10, 2'b10, 1'b0, 2'b00);
        checkOutput("bp_ready", 32'(req_ready), 32'd2);
        step();
        req_valid = 2'b01;
        step();
        core_done = 1'b1;
        step();
        core_done = 1'b0;
        for (int i = 0; i < 10; i++) begin
            checkOutput("bp_rsp", 32'(rsp_valid), 32'd2);
            checkOutput("bp_busy", 32'(busy), 32'd1);
            checkOutput("bp_nostart", 32'(core_start), 32'd0);
            step();
        end
        checkOutput("bp_hold_rsp", 32'(rsp_valid), 32'd2);
        rsp_ready = 2'b10;
        step();
        checkOutput("bp_release_busy", 32'(busy), 32'd0);
        checkOutput("bp_release_rsp", 32'(rsp_valid), 32'd0);
        checkOutput("bp_next_ready", 32'(req_ready), 32'd1);
        applyStimulus(2'b00, 2'b00, 1'b0, 2'b00);

        // Spurious core_done in IDLE and in ISSUE.
        core_done = 1'b1;
        step();
        checkOutput("spur_idle_busy", 32'(busy), 32'd0);
        checkOutput("spur_idle_rsp", 32'(rsp_valid), 32'd0);
        applyStimulus(2'b01, 2'b00, 1'b0, 2'b00);
        step();
        checkOutput("spur_issue_start", 32'(core_start), 32'd1);
        applyStimulus(2'b00, 2'b00, 1'b1, 2'b00);
        step();
        checkOutput("spur_issue_rsp", 32'(rsp_valid), 32'd0);
        checkOutput("spur_issue_busy", 32'(busy), 32'd1);
        checkOutput("spur_issue_start2", 32'(core_start), 32'd0);
        core_done = 1'b0;
        step();
        checkOutput("spur_wait_rsp", 32'(rsp_valid), 32'd0);
        checkOutput("spur_wait_busy", 32'(busy), 32'd1);
        core_done = 1'b1;
        step();
        checkOutput("spur_final_rsp", 32'(rsp_valid), 32'd1);
        applyStimulus(2'b00, 2'b00, 1'b0, 2'b01);
        step();
        checkOutput("spur_final_busy", 32'(busy), 32'd0);

        // Reset while in WAIT, then a stale core_done.
        applyStimulus(2'b01, 2'b01, 1'b0, 2'b00);
        step();
        applyStimulus(2'b00, 2'b00, 1'b0, 2'b00);
        step();
        checkOutput("rstwait_busy_pre", 32'(busy), 32'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        core_done = 1'b1;
        step();
        checkOutput("rstwait_busy", 32'(busy), 32'd0);
        checkOutput("rstwait_rsp", 32'(rsp_valid), 32'd0);
        checkOutput("rstwait_start", 32'(core_start), 32'd0);
        checkOutput("rstwait_mode", 32'(core_mode), 32'd0);
        core_done = 1'b0;
        step();
        checkOutput("rstwait_still_idle", 32'(busy), 32'd0);

        // No core_done at all: timeout abort or indefinite WAIT depending on the build.
        applyStimulus(2'b01, 2'b00, 1'b0, 2'b00);
        step();
        applyStimulus(2'b00, 2'b00, 1'b0, 2'b00);
        step();
        repeat (15) step();
        checkOutput("to_wait15_rsp", 32'(rsp_valid), 32'd0);
        checkOutput("to_wait15_busy", 32'(busy), 32'd1);
        step();
`ifdef CORDIC_ARB_TIMEOUT_EN
        checkOutput("to_rsp", 32'(rsp_valid), 32'd1);
        checkOutput("to_err", 32'(rsp_err), 32'd1);
        rsp_ready = 2'b01;
        step();
        checkOutput("to_release_busy", 32'(busy), 32'd0);
        checkOutput("to_release_err", 32'(rsp_err), 32'd0);
`else
        repeat (40) step();
        checkOutput("nto_busy", 32'(busy), 32'd1);
        checkOutput("nto_rsp", 32'(rsp_valid), 32'd0);
        checkOutput("nto_err", 32'(rsp_err), 32'd0);
        core_done = 1'b1;
        step();
        core_done = 1'b0;
        checkOutput("nto_late_rsp", 32'(rsp_valid), 32'd1);
        checkOutput("nto_late_err", 32'(rsp_err), 32'd0);
        rsp_ready = 2'b01;
        step();
        checkOutput("nto_release_busy", 32'(busy), 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, mismatch_count);
        $finish;
    end

endmodule
